// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between an async FIFO's show-ahead read port, the reader,
// and the downstream valid/ready stream consumer.
interface fifo_stream_reader_if #(parameter int DATA_WIDTH = 8);
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_fifo_rd_en;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;
  logic [1:0]            o_level;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_ready,
    output o_fifo_rd_en, o_valid, o_data, o_last, o_level
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_ready,
    input  o_fifo_rd_en, o_valid, o_data, o_last, o_level
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a 2-entry registered valid/ready stream and
// marks every PACKET_LEN-th transferred beat with o_last.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PACKET_LEN = 4
) (
  input logic                 i_clock,
  input logic                 i_reset,
  fifo_stream_reader_if.master bus
);
  localparam int CW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] head_q, skid_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  push, out, valid, at_last;

  // Pop decision uses only registered occupancy, so i_ready never reaches rd_en.
  assign push    = !i_reset && !bus.i_fifo_empty && (state_q != TWO);
  assign valid   = (state_q != EMPTY);
  assign out     = valid && bus.i_ready;
  assign at_last = (cnt_q == CW'(PACKET_LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (out) cnt_d = at_last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        EMPTY: if (push) begin
          head_q  <= bus.i_fifo_data;
          state_q <= ONE;
        end
        ONE: begin
          if (push && out) begin
            head_q <= bus.i_fifo_data;
          end else if (push) begin
            skid_q  <= bus.i_fifo_data;
            state_q <= TWO;
          end else if (out) begin
            state_q <= EMPTY;
          end
        end
        TWO: if (out) begin
          head_q  <= skid_q;
          state_q <= ONE;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.o_fifo_rd_en = push;
  assign bus.o_valid      = valid;
  assign bus.o_data       = head_q;
  assign bus.o_last       = valid && at_last;
  assign bus.o_level      = state_q;
endmodule
